// File: rtl/kernel_kcore_arb_pkg.sv
// Shared types and round-robin pick helper for the kcore FIFO write arbiter.
// Pure declarations. No timing and no backpressure of its own.
package kernel_kcore_arb_pkg;

  typedef enum logic {IDLE, BURST} arb_state_t;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_MAX_BURST  = 4;

  // Rotate valid so ptr sits at bit 0, take the lowest set bit, then rotate the index back.
  // Supports up to 8 requesters. Result is {found, index[2:0]}.
  function automatic logic [3:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr,
                                         input int num_req);
    logic [7:0] rot;
    int         first;
    int         idx;
    logic [3:0] res;
    rot = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < num_req) rot[3'(i)] = valid[3'((int'(ptr) + i) % num_req)];
    end
    first = -1;
    for (int i = 7; i >= 0; i--) begin
      if (rot[3'(i)]) first = i;
    end
    res = '0;
    if (first >= 0) begin
      idx = (int'(ptr) + first) % num_req;
      res = {1'b1, 3'(idx)};
    end
    return res;
  endfunction

endpackage

// File: rtl/kernel_kcore_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr, modulo NUM_REQ.
// Zero latency. No backpressure; the caller qualifies the pick.
module kernel_kcore_rr_pick
  import kernel_kcore_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int GNT_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   valid,
  input  logic [GNT_WIDTH-1:0] rr_ptr,
  output logic [GNT_WIDTH-1:0] pick,
  output logic                 found
);

  logic [7:0] valid_ext;
  logic [3:0] res;

  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = valid;
    res                      = rr_pick(valid_ext, 3'(rr_ptr), NUM_REQ);
  end

  assign pick  = GNT_WIDTH'(res[2:0]);
  assign found = res[3];

endmodule

// File: rtl/kernel_kcore_fifo_wr_arb.sv
// Round-robin N:1 arbiter onto the kcore FIFO write port, bounded bursts; optional KCORE_FIFO_ARB_STATS_EN adds per-requester beat counters.
// One cycle accept->if_write; ready is withheld only while the output register is full and the FIFO is full.
module kernel_kcore_fifo_wr_arb
  import kernel_kcore_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  parameter int GNT_WIDTH  = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          if_full_n,
  output logic                          if_write,
  output logic                          if_write_ce,
  output logic [DATA_WIDTH-1:0]         if_din,
  output logic [GNT_WIDTH-1:0]          cur_gnt,
  output logic                          busy
`ifdef KCORE_FIFO_ARB_STATS_EN
  ,
  input  logic                          stats_clr,
  output logic [NUM_REQ*32-1:0]         gnt_cnt
`endif
);

  localparam int                   CNT_WIDTH  = $clog2(MAX_BURST + 1);
  localparam logic [CNT_WIDTH-1:0] BURST_LAST = CNT_WIDTH'(MAX_BURST);
  localparam logic [GNT_WIDTH-1:0] LAST_REQ   = GNT_WIDTH'(NUM_REQ - 1);

  arb_state_t            state;
  logic [GNT_WIDTH-1:0]  rr_ptr;
  logic [GNT_WIDTH-1:0]  pick;
  logic [GNT_WIDTH-1:0]  sel;
  logic [GNT_WIDTH-1:0]  sel_inc;
  logic                  found;
  logic                  sel_en;
  logic                  can_load;
  logic                  accept;
  logic                  burst_done;
  logic                  valid_drop;
  logic                  out_valid;
  logic [CNT_WIDTH-1:0]  burst_cnt;
  logic [CNT_WIDTH-1:0]  cnt_next;
  logic [DATA_WIDTH-1:0] out_data;
  logic [DATA_WIDTH-1:0] sel_data;

  kernel_kcore_rr_pick #(
    .NUM_REQ   (NUM_REQ),
    .GNT_WIDTH (GNT_WIDTH)
  ) u_pick (
    .valid  (req_valid),
    .rr_ptr (rr_ptr),
    .pick   (pick),
    .found  (found)
  );

  // In IDLE the fresh pick drives ready directly, so a new burst starts without a bubble.
  assign can_load   = ~out_valid | if_full_n;
  assign sel        = (state == IDLE) ? pick : cur_gnt;
  assign sel_en     = (state == IDLE) ? found : 1'b1;
  assign accept     = sel_en & can_load & req_valid[sel];
  assign sel_data   = req_data[sel*DATA_WIDTH +: DATA_WIDTH];
  assign cnt_next   = (state == IDLE) ? CNT_WIDTH'(1) : burst_cnt + 1'b1;
  assign burst_done = accept & (cnt_next == BURST_LAST);
  assign valid_drop = (state == BURST) & ~req_valid[cur_gnt] & can_load;
  assign sel_inc    = (sel == LAST_REQ) ? '0 : sel + 1'b1;

  always_comb begin
    req_ready = '0;
    if (sel_en) req_ready[sel] = can_load;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_gnt   <= '0;
      burst_cnt <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
      end else if (if_full_n) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (found) begin
            cur_gnt <= pick;
            // A single-beat burst finishes in the same cycle it was granted.
            if (burst_done) begin
              rr_ptr    <= sel_inc;
              burst_cnt <= '0;
            end else begin
              state     <= BURST;
              burst_cnt <= accept ? cnt_next : '0;
            end
          end
        end
        BURST: begin
          if (burst_done || valid_drop) begin
            state     <= IDLE;
            rr_ptr    <= sel_inc;
            burst_cnt <= '0;
          end else if (accept) begin
            burst_cnt <= cnt_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign if_write    = out_valid;
  assign if_din      = out_data;
  assign if_write_ce = 1'b1;
  assign busy        = (state == BURST) | out_valid;

`ifdef KCORE_FIFO_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stats_clr) gnt_cnt[i*32 +: 32] <= '0;
        else if (accept && (sel == GNT_WIDTH'(i))) gnt_cnt[i*32 +: 32] <= gnt_cnt[i*32 +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_kernel_kcore_fifo_wr_arb.sv
// Directed bench for kernel_kcore_fifo_wr_arb: vector table for rotation/backpressure, hand sequences for the corners.
// Producers present beat k of requester r as {r[7:0], k[55:0]} and advance on each accepted beat.
module tb_kernel_kcore_fifo_wr_arb;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int NV = 19;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            if_full_n;
  logic            if_write;
  logic            if_write_ce;
  logic [DW-1:0]   if_din;
  logic [1:0]      cur_gnt;
  logic            busy;
`ifdef KCORE_FIFO_ARB_STATS_EN
  logic            stats_clr;
  logic [N*32-1:0] gnt_cnt;
`endif

  always #5 clk = ~clk;

  kernel_kcore_fifo_wr_arb dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .if_full_n   (if_full_n),
    .if_write    (if_write),
    .if_write_ce (if_write_ce),
    .if_din      (if_din),
    .cur_gnt     (cur_gnt),
    .busy        (busy)
`ifdef KCORE_FIFO_ARB_STATS_EN
    ,
    .stats_clr   (stats_clr),
    .gnt_cnt     (gnt_cnt)
`endif
  );

  typedef struct {
    logic [N-1:0] en;
    logic         full_n;
    logic         wr;
    logic [63:0]  din;
    logic [1:0]   gnt;
    logic [N-1:0] rdy;
    logic         busy;
  } vec_t;

  vec_t         vecs[NV];
  int           errors = 0;
  int           checks = 0;
  int           seq[N];
  int           lim[N];
  logic [N-1:0] en;
  logic [N-1:0] acc;
  int           first_acc;
  int           nw;

  function automatic logic [63:0] dd(input int r, input int k);
    return (64'(r) << 56) | 64'(k);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = en[i] && (seq[i] <= lim[i]);
      req_data[i*DW +: DW]    = dd(i, seq[i]);
    end
  endtask

  // Sample handshakes at the negedge, advance producers just after the posedge.
  task automatic tick();
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) seq[i]++;
    drive();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    en        = '0;
    if_full_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      seq[i] = 1;
      lim[i] = 1000;
    end
`ifdef KCORE_FIFO_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    drive();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    vecs[0]  = '{4'hF, 1'b1, 1'b0, 64'h0,    2'd0, 4'b0001, 1'b0};
    vecs[1]  = '{4'hF, 1'b1, 1'b1, dd(0, 1), 2'd0, 4'b0001, 1'b1};
    vecs[2]  = '{4'hF, 1'b1, 1'b1, dd(0, 2), 2'd0, 4'b0001, 1'b1};
    vecs[3]  = '{4'hF, 1'b1, 1'b1, dd(0, 3), 2'd0, 4'b0001, 1'b1};
    vecs[4]  = '{4'hF, 1'b1, 1'b1, dd(0, 4), 2'd0, 4'b0010, 1'b1};
    vecs[5]  = '{4'hF, 1'b1, 1'b1, dd(1, 1), 2'd1, 4'b0010, 1'b1};
    vecs[6]  = '{4'hF, 1'b1, 1'b1, dd(1, 2), 2'd1, 4'b0010, 1'b1};
    vecs[7]  = '{4'hF, 1'b1, 1'b1, dd(1, 3), 2'd1, 4'b0010, 1'b1};
    vecs[8]  = '{4'hF, 1'b1, 1'b1, dd(1, 4), 2'd1, 4'b0100, 1'b1};
    vecs[9]  = '{4'hF, 1'b1, 1'b1, dd(2, 1), 2'd2, 4'b0100, 1'b1};
    for (int r = 10; r < 15; r++) vecs[r] = '{4'hF, 1'b0, 1'b1, dd(2, 2), 2'd2, 4'b0000, 1'b1};
    vecs[15] = '{4'hF, 1'b1, 1'b1, dd(2, 2), 2'd2, 4'b0100, 1'b1};
    vecs[16] = '{4'hF, 1'b1, 1'b1, dd(2, 3), 2'd2, 4'b0100, 1'b1};
    vecs[17] = '{4'hF, 1'b1, 1'b1, dd(2, 4), 2'd2, 4'b1000, 1'b1};
    vecs[18] = '{4'hF, 1'b1, 1'b1, dd(3, 1), 2'd3, 4'b1000, 1'b1};

    // Reset state
    do_reset();
    chk("rst.ready", 64'(req_ready), 64'h0);
    chk("rst.write", 64'(if_write), 64'h0);
    chk("rst.din", if_din, 64'h0);
    chk("rst.gnt", 64'(cur_gnt), 64'h0);
    chk("rst.busy", 64'(busy), 64'h0);
    chk("rst.ce", 64'(if_write_ce), 64'h1);

    // Rotation across all requesters, then a 5-cycle full stall mid-burst
    for (int r = 0; r < NV; r++) begin
      en        = vecs[r].en;
      if_full_n = vecs[r].full_n;
      drive();
      #1;
      chk($sformatf("vec%0d.ready", r), 64'(req_ready), 64'(vecs[r].rdy));
      chk($sformatf("vec%0d.write", r), 64'(if_write), 64'(vecs[r].wr));
      chk($sformatf("vec%0d.din", r), if_din, vecs[r].din);
      chk($sformatf("vec%0d.gnt", r), 64'(cur_gnt), 64'(vecs[r].gnt));
      chk($sformatf("vec%0d.busy", r), 64'(busy), 64'(vecs[r].busy));
      tick();
    end

    // Lone requester 2 streams 10 beats back-to-back across burst boundaries
    do_reset();
    en        = 4'b0100;
    lim[2]    = 10;
    first_acc = -1;
    nw        = 0;
    for (int c = 0; c < 30; c++) begin
      drive();
      #1;
      if (if_write) begin
        chk("t1.din", if_din, dd(2, nw + 1));
        chk("t1.timing", 64'(c), 64'(first_acc + 1 + nw));
        chk("t1.gnt", 64'(cur_gnt), 64'd2);
        nw++;
      end
      if (first_acc < 0 && req_valid[2] && req_ready[2]) first_acc = c;
      tick();
    end
    chk("t1.count", 64'(nw), 64'd10);

    // Requester 1 drops after 2 beats; requester 3 must win next
    do_reset();
    en     = 4'b1010;
    lim[1] = 2;
    drive();
    #1;
    chk("t4.c0.ready", 64'(req_ready), 64'b0010);
    tick();
    chk("t4.c1.gnt", 64'(cur_gnt), 64'd1);
    chk("t4.c1.din", if_din, dd(1, 1));
    tick();
    chk("t4.c2.din", if_din, dd(1, 2));
    chk("t4.c2.valid1", 64'(req_valid[1]), 64'd0);
    tick();
    chk("t4.c3.ready", 64'(req_ready), 64'b1000);
    chk("t4.c3.gnt", 64'(cur_gnt), 64'd1);
    tick();
    chk("t4.c4.gnt", 64'(cur_gnt), 64'd3);
    chk("t4.c4.din", if_din, dd(3, 1));

    // Reset mid-burst with a beat in the output register
    do_reset();
    en = 4'hF;
    drive();
    #1;
    tick();
    tick();
    chk("t5.pre.write", 64'(if_write), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("t5.rst.write", 64'(if_write), 64'd0);
    chk("t5.rst.busy", 64'(busy), 64'd0);
    chk("t5.rst.gnt", 64'(cur_gnt), 64'd0);
    en = 4'b1010;
    drive();
    @(negedge clk);
    reset_n = 1'b1;
    drive();
    #1;
    chk("t5.rel.ready", 64'(req_ready), 64'b0010);
    tick();
    chk("t5.rel.gnt", 64'(cur_gnt), 64'd1);
    chk("t5.rel.write", 64'(if_write), 64'd1);
    chk("t5.rel.din", if_din, dd(1, 1));

`ifdef KCORE_FIFO_ARB_STATS_EN
    do_reset();
    en     = 4'b0011;
    lim[0] = 7;
    lim[1] = 3;
    drive();
    #1;
    repeat (20) tick();
    chk("st.cnt0", 64'(gnt_cnt[31:0]), 64'd7);
    chk("st.cnt1", 64'(gnt_cnt[63:32]), 64'd3);
    chk("st.cnt23", 64'(gnt_cnt[127:64]), 64'd0);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    #1;
    chk("st.clr", 64'(gnt_cnt[63:0] | gnt_cnt[127:64]), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kernel_kcore_fifo_wr_arb.md
Name: kernel_kcore_fifo_wr_arb

Overview:
- N-way round-robin write arbiter that shares one kernel_kcore FIFO write port (full_n/write/din handshake) between N producer streams.
- Sits between the kcore edge/vertex producer stages and the shared 64-bit FIFO.
- Grants one requester at a time, holds the grant for a bounded burst, then rotates priority.
- Registers the output once, so there is exactly one cycle from accept to FIFO write.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 64, payload width; must match the FIFO DATA_WIDTH.
- MAX_BURST, 4, maximum consecutive beats per grant (1..16).
- GNT_WIDTH, 2, width of the grant index; equals clog2(NUM_REQ).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester data valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot or zero; beat i is accepted when req_valid[i] & req_ready[i].
- if_full_n  in  1  FIFO not-full.
- if_write  out  1  FIFO write strobe.
- if_write_ce  out  1  tied 1.
- if_din  out  DATA_WIDTH  FIFO write data.
- cur_gnt  out  GNT_WIDTH  index of the current or last granted requester.
- busy  out  1  high while state is BURST or the output register holds data.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, cur_gnt=0, burst_cnt=0, out_valid=0, if_write=0, if_din=0, req_ready=0, busy=0.
- Output register: if_write=out_valid and if_din=out_data.
- The output register drains when out_valid & if_full_n.
- can_load = ~out_valid | if_full_n.
- IDLE state:
  - Pick the first requester with req_valid set, searching from rr_ptr upward modulo NUM_REQ.
  - If one is found, it becomes cur_gnt, burst_cnt=0, and the state moves to BURST in the same cycle.
  - req_ready in IDLE is combinational from the pick: req_ready[pick]=can_load. The first beat is therefore accepted with zero arbitration bubble.
- BURST state:
  - req_ready[cur_gnt]=can_load; all other bits are 0.
  - On accept: out_data<=req_data[cur_gnt], out_valid<=1, burst_cnt+1.
  - The burst ends when the accepted beat makes burst_cnt==MAX_BURST, or when req_valid[cur_gnt]=0 while can_load=1.
  - At burst end: rr_ptr<=cur_gnt+1 (wraps to 0 after NUM_REQ-1) and state<=IDLE.
- While the FIFO is full (if_full_n=0, out_valid=1):
  - Nothing is accepted and the grant is frozen.
  - The burst does not end on a valid drop in this condition.
- out_valid clears when the register drains and no new beat is accepted in the same cycle.
- Simultaneous drain and accept in one cycle gives full throughput: one beat per cycle.
- No beat is duplicated or dropped.
- A requester's beat order is preserved.
- Between requesters, order follows grant order.
- Fairness: any requester held valid is granted within (NUM_REQ-1)*MAX_BURST accepted beats.
- Reset mid-burst: any beat still in the output register is discarded, and producers must re-present it.

Optional Feature:
- Macro: KCORE_FIFO_ARB_STATS_EN.
- When defined:
  - Adds output gnt_cnt (NUM_REQ*32), one counter per requester of accepted beats.
  - Counters wrap at 2^32 and are cleared by reset_n.
  - Adds input stats_clr (1), a synchronous clear of all counters. Clear takes priority over an increment in the same cycle.
- When undefined: neither port exists, and the logic is identical otherwise.

Decomposition:
- Shared package kernel_kcore_arb_pkg holds:
  - state enum {IDLE, BURST};
  - default constants DATA_WIDTH=64 and MAX_BURST=4;
  - a function that computes the round-robin pick from valid and rr_ptr.
- One sub-module, kernel_kcore_rr_pick: combinational rotate, priority encode, unrotate, producing pick index and found flag.
- The output register stays in the top module.

Test Plan:
- Single requester 2 streams 10 beats (0x1..0xA), if_full_n=1 → if_din shows 0x1..0xA, one per cycle. First if_write one cycle after first accept. cur_gnt=2 throughout.
- All 4 requesters continuously valid, MAX_BURST=4 → grant order 0,0,0,0,1,1,1,1,2,..., with no idle cycle between bursts.
- if_full_n=0 for 5 cycles mid-burst → if_write/if_din held stable, req_ready=0, burst_cnt unchanged. Resume with no loss or duplication.
- Requester 1 drops valid after 2 beats while requester 3 is waiting → burst ends and rr_ptr=2, so requester 3 is granted next.
- reset_n asserted mid-burst with out_valid=1 → if_write=0 and busy=0 immediately. After release, the first grant goes to the lowest valid index.
- With KCORE_FIFO_ARB_STATS_EN defined, 7 beats from requester 0 and 3 from requester 1 → gnt_cnt[0]=7 and gnt_cnt[1]=3. Pulsing stats_clr → all counters 0.
